// File: rtl/mux4_rr_arbiter.sv
// Four-way round-robin arbiter that registers the granted word into a single valid/ready output stage.
// Latency: the word is in o_data one cycle after capture; o_ack is asserted in the same cycle as the capture.
// Backpressure: while o_valid is high and i_ready is low, the output holds and no requester is acked.
module mux4_rr_arbiter #(
  parameter int SIZE        = 32,
  parameter int SIZE_SELECT = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [3:0]             i_req,
  input  logic [3:0]             i_mask,
  input  logic [SIZE-1:0]        i_A,
  input  logic [SIZE-1:0]        i_B,
  input  logic [SIZE-1:0]        i_C,
  input  logic [SIZE-1:0]        i_D,
  input  logic                   i_ready,
  output logic [SIZE-1:0]        o_data,
  output logic                   o_valid,
  output logic [SIZE_SELECT-1:0] o_SEL,
  output logic [3:0]             o_ack,
  output logic [7:0]             o_count
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state;
  logic [SIZE_SELECT-1:0] ptr;
  logic [SIZE_SELECT-1:0] winner;
  logic [SIZE_SELECT-1:0] idx;
  logic [3:0]             eligible;
  logic                   found;
  logic                   any_req;
  logic                   capture;
  logic [SIZE-1:0]        win_data;

  // Search starts at ptr and wraps, so the last winner drops to lowest priority.
  always_comb begin
    eligible = i_req & i_mask;
    winner   = '0;
    idx      = '0;
    found    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + SIZE_SELECT'(k);
      if (!found && eligible[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req = |eligible;
  assign capture = any_req && (!o_valid || i_ready) && !i_reset;
  assign o_ack   = capture ? (4'b0001 << winner) : 4'b0000;

  always_comb begin
    case (winner)
      2'd0:    win_data = i_A;
      2'd1:    win_data = i_B;
      2'd2:    win_data = i_C;
      default: win_data = i_D;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_SEL   <= '0;
      o_count <= '0;
      ptr     <= '0;
    end else begin
      if (o_valid && i_ready)
        o_count <= o_count + 8'd1;
      case (state)
        IDLE: begin
          if (capture) begin
            o_data  <= win_data;
            o_SEL   <= winner;
            ptr     <= winner + SIZE_SELECT'(1);
            o_valid <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (i_ready) begin
            // A pending request refills the output on the same edge it drains.
            if (capture) begin
              o_data <= win_data;
              o_SEL  <= winner;
              ptr    <= winner + SIZE_SELECT'(1);
            end else begin
              o_valid <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          o_valid <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: reset, capture, backpressure, fairness, masking and count wrap.
// Inputs change #1 after each rising edge; the combinational o_ack is sampled one time unit after the inputs change.
module tb_mux4_rr_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [3:0]  i_req;
  logic [3:0]  i_mask;
  logic [31:0] i_A, i_B, i_C, i_D;
  logic        i_ready;
  logic [31:0] o_data;
  logic        o_valid;
  logic [1:0]  o_SEL;
  logic [3:0]  o_ack;
  logic [7:0]  o_count;

  int n_cmp = 0;
  int n_err = 0;

  mux4_rr_arbiter #(.SIZE(32), .SIZE_SELECT(2)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_req   (i_req),
    .i_mask  (i_mask),
    .i_A     (i_A),
    .i_B     (i_B),
    .i_C     (i_C),
    .i_D     (i_D),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_SEL   (o_SEL),
    .o_ack   (o_ack),
    .o_count (o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_reset = 1'b1; i_req = 4'b0001; i_mask = 4'b1111; i_ready = 1'b0;
    i_A = 32'h11; i_B = 32'h22; i_C = 32'h33; i_D = 32'h44;
    tick(); tick();
    chk("rst_ack", o_ack, 4'b0000);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_data", o_data, 32'h0);
    chk("rst_sel", o_SEL, 2'd0);
    chk("rst_count", o_count, 8'd0);

    // First capture of requester A.
    i_reset = 1'b0;
    #1 chk("first_ack", o_ack, 4'b0001);
    tick();
    chk("first_valid", o_valid, 1'b1);
    chk("first_data", o_data, 32'h11);
    chk("first_sel", o_SEL, 2'd0);

    // Back-to-back capture of B; the pointer now sits at 2.
    i_req = 4'b0010; i_ready = 1'b1;
    #1 chk("b_ack", o_ack, 4'b0010);
    tick();
    chk("b_data", o_data, 32'h22);
    chk("b_count", o_count, 8'd1);

    // Backpressure for five cycles while C requests.
    i_req = 4'b0100; i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_ack", o_ack, 4'b0000);
      tick();
      chk("bp_data", o_data, 32'h22);
      chk("bp_sel", o_SEL, 2'd1);
      chk("bp_count", o_count, 8'd1);
      chk("bp_valid", o_valid, 1'b1);
    end
    i_ready = 1'b1;
    #1 chk("c_ack", o_ack, 4'b0100);
    tick();
    chk("c_data", o_data, 32'h33);
    chk("c_sel", o_SEL, 2'd2);
    chk("c_count", o_count, 8'd2);

    // Drain to IDLE; data and select hold, and i_ready is ignored in IDLE.
    i_req = 4'b0000;
    tick();
    chk("drain_valid", o_valid, 1'b0);
    chk("drain_count", o_count, 8'd3);
    chk("drain_data", o_data, 32'h33);
    chk("drain_sel", o_SEL, 2'd2);
    tick();
    chk("idle_count", o_count, 8'd3);
    chk("idle_valid", o_valid, 1'b0);

    // All request from pointer 3: D, A, B.
    i_req = 4'b1111;
    #1 chk("rr3_ack", o_ack, 4'b1000);
    tick();
    chk("rr3_sel", o_SEL, 2'd3);
    chk("rr3_data", o_data, 32'h44);
    chk("rr3_count", o_count, 8'd3);
    #1 chk("rr0_ack", o_ack, 4'b0001);
    tick();
    chk("rr0_sel", o_SEL, 2'd0);
    chk("rr0_count", o_count, 8'd4);
    #1 chk("rr1_ack", o_ack, 4'b0010);
    tick();
    chk("rr1_sel", o_SEL, 2'd1);
    chk("rr1_count", o_count, 8'd5);

    // Reset in BUSY with count 5 discards the word.
    i_reset = 1'b1;
    #1 chk("rstbusy_ack", o_ack, 4'b0000);
    tick();
    chk("rstbusy_valid", o_valid, 1'b0);
    chk("rstbusy_count", o_count, 8'd0);
    chk("rstbusy_data", o_data, 32'h0);
    i_reset = 1'b0; i_req = 4'b1000;
    #1 chk("postrst_ack", o_ack, 4'b1000);
    tick();
    chk("postrst_sel", o_SEL, 2'd3);
    chk("postrst_data", o_data, 32'h44);
    chk("postrst_count", o_count, 8'd0);

    // Fairness: pointer is 0, so the expected order is 0,1,2,3,0.
    i_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 chk("fair_ack", o_ack, 64'(4'b0001 << (k % 4)));
      tick();
      chk("fair_sel", o_SEL, 64'(k % 4));
      chk("fair_count", o_count, 64'(k + 1));
    end

    // Masking: only B may be granted.
    i_req = 4'b1010; i_mask = 4'b0010;
    for (int j = 0; j < 4; j++) begin
      #1 chk("mask_ack", o_ack, 4'b0010);
      tick();
      chk("mask_sel", o_SEL, 2'd1);
      chk("mask_count", o_count, 64'(6 + j));
    end
    i_req = 4'b0000;
    tick();
    chk("mask_drain_valid", o_valid, 1'b0);
    chk("mask_drain_count", o_count, 8'd10);
    i_req = 4'b1010; i_mask = 4'b0000;
    for (int j = 0; j < 3; j++) begin
      #1 chk("mask0_ack", o_ack, 4'b0000);
      tick();
      chk("mask0_valid", o_valid, 1'b0);
      chk("mask0_count", o_count, 8'd10);
    end

    // Masking a captured requester still delivers its word.
    i_mask = 4'b1111; i_req = 4'b0001; i_ready = 1'b0;
    #1 chk("held_ack", o_ack, 4'b0001);
    tick();
    chk("held_data", o_data, 32'h11);
    i_mask = 4'b0000; i_req = 4'b0000; i_ready = 1'b1;
    #1 chk("held_ack_masked", o_ack, 4'b0000);
    tick();
    chk("held_delivered_valid", o_valid, 1'b0);
    chk("held_delivered_count", o_count, 8'd11);

    // Count wrap: 256 accepted transfers from zero.
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0; i_req = 4'b1111; i_mask = 4'b1111; i_ready = 1'b1;
    tick();
    chk("wrap_start_count", o_count, 8'd0);
    chk("wrap_start_sel", o_SEL, 2'd0);
    for (int w = 0; w < 255; w++) tick();
    chk("wrap_255_count", o_count, 8'd255);
    chk("wrap_255_valid", o_valid, 1'b1);
    i_req = 4'b0000;
    tick();
    chk("wrap_0_count", o_count, 8'd0);
    chk("wrap_0_valid", o_valid, 1'b0);
    chk("wrap_0_sel", o_SEL, 2'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 The block SHALL be clocked by a single clock and SHALL use a synchronous, active-high reset.
REQ-002 Parameter SIZE, default 32, SHALL set the data width of every requester and of the output.
REQ-003 Parameter SIZE_SELECT, default 2, SHALL set the select/index width; only the value 2 is supported.
REQ-004 i_clk  input  1  SHALL be the block clock; all state updates occur on its rising edge.
REQ-005 i_reset  input  1  SHALL be the synchronous, active-high reset.
REQ-006 i_req  input  4  SHALL be the per-requester request; bit n belongs to requester n (n = 0..3, A..D).
REQ-007 i_mask  input  4  SHALL be the per-requester enable; a requester with mask bit 0 is never granted.
REQ-008 i_A, i_B, i_C, i_D  input  SIZE each  SHALL be the requester data words for requesters 0..3.
REQ-009 i_ready  input  1  SHALL be the downstream consumer accept.
REQ-010 o_data  output  SIZE  SHALL be the registered, granted data word.
REQ-011 o_valid  output  1  SHALL indicate that o_data holds an unaccepted word.
REQ-012 o_SEL  output  SIZE_SELECT  SHALL be the registered index of the requester whose word is in o_data.
REQ-013 o_ack  output  4  SHALL be the one-hot, combinational capture acknowledge to requesters.
REQ-014 o_count  output  8  SHALL be the number of completed downstream transfers, modulo 256.

Function
REQ-015 Eligible set SHALL be i_req AND i_mask; any_req = OR of the eligible set.
REQ-016 Winner SHALL be the first eligible index found searching ptr, ptr+1, ptr+2, ptr+3 (mod 4), where ptr is a 2-bit round-robin pointer.
REQ-017 capture SHALL be any_req AND (NOT o_valid OR i_ready), evaluated combinationally each cycle.
REQ-018 o_ack SHALL equal the one-hot winner when capture = 1, and 4'b0000 otherwise; requesters drop or update their request in the cycle after their ack.
REQ-019 On a capture edge, the block SHALL load o_data with the winner's word, set o_SEL to the winner index, set o_valid = 1, and set ptr = winner+1 mod 4.
REQ-020 State machine: IDLE (o_valid = 0) and BUSY (o_valid = 1).
REQ-021 IDLE: on capture go to BUSY; otherwise stay in IDLE.
REQ-022 BUSY with i_ready = 0: o_data, o_SEL, o_valid and ptr SHALL hold, and o_ack SHALL be 0.
REQ-023 BUSY with i_ready = 1 and any_req = 1: the block SHALL capture the next winner back-to-back in the same edge and stay in BUSY, for a throughput of one word per cycle.
REQ-024 BUSY with i_ready = 1 and any_req = 0: go to IDLE with o_valid = 0; o_data and o_SEL hold their last value.
REQ-025 o_count SHALL increment by 1 on every edge where o_valid = 1 and i_ready = 1, and SHALL wrap from 255 to 0.
REQ-026 i_ready SHALL be ignored while o_valid = 0: no count change and no state change.
REQ-027 Changes to i_mask SHALL affect only future captures; a word already in o_data is still delivered.
REQ-028 Capture latency SHALL be 1 cycle from request to o_valid in IDLE; o_ack is same-cycle.

Reset
REQ-029 While i_reset = 1 at a clock edge, the block SHALL set o_valid = 0, o_data = 0, o_SEL = 0, o_count = 0, ptr = 0 and state = IDLE.
REQ-030 While i_reset = 1, o_ack SHALL be forced to 4'b0000 regardless of i_req.
REQ-031 A reset mid-transfer SHALL discard the held word; it SHALL NOT be counted or re-acked.

Verification
REQ-032 Reset, then i_req = 0001, i_A = 0x11, mask = 1111 -> o_ack = 0001 same cycle; next cycle o_valid = 1, o_data = 0x11, o_SEL = 0, ptr = 1.
REQ-033 Round-robin fairness: i_req = 1111 held, i_ready = 1 -> o_SEL sequence 0,1,2,3,0 on consecutive cycles, and o_count increments by 1 per cycle.
REQ-034 Backpressure: o_valid = 1 with o_data = 0x22 and i_ready = 0 for 5 cycles, i_req = 0100 -> o_data, o_SEL and o_count are stable, o_ack = 0; on i_ready = 1, o_ack = 0100 and the C word is loaded the next edge.
REQ-035 Mask: i_req = 1010, i_mask = 0010 -> only requester 1 is ever acked; with i_mask = 0000 the block stays in IDLE and o_ack = 0.
REQ-036 Wrap: 256 accepted transfers -> o_count returns to 0x00; drain with i_req = 0 -> o_valid = 0 one cycle after the last accept.
REQ-037 Reset in BUSY with o_count = 5 -> next cycle o_valid = 0, o_count = 0; a subsequent i_req = 1000 is granted D first (ptr = 0 search reaches 3).
